// File: rtl/bin_sensor_scanner.sv
// Round-robin scanner for three bin level-switch banks on a shared 8-bit bus.
// Each pass settles, samples, then commits AND pattern, average fill, LED bar and full flag.
//   state  | meaning
//   IDLE   | parked; results and SENSOR_sel held
//   SELECT | drive SENSOR_sel, clear accumulator/pattern/counter
//   SETTLE | wait for the selected switch bank to settle
//   SAMPLE | accumulate popcount and AND the raw pattern
//   COMMIT | write this bin's results, advance bin index
module bin_sensor_scanner #(
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLES       = 4,
    parameter int FULL_THRESH   = 7
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       scan_en,
    input  logic [7:0] SENSOR_raw,
    output logic [1:0] SENSOR_sel,
    output logic [7:0] SENSOR_bin1,
    output logic [7:0] SENSOR_bin2,
    output logic [7:0] SENSOR_bin3,
    output logic [3:0] VALUE_bin1,
    output logic [3:0] VALUE_bin2,
    output logic [3:0] VALUE_bin3,
    output logic [7:0] STATUS_bin1,
    output logic [7:0] STATUS_bin2,
    output logic [7:0] STATUS_bin3,
    output logic [2:0] FULL_flags,
    output logic       update
);

    localparam int          SHIFT       = $clog2(SAMPLES);
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  SAMPLE_LAST = 4'(SAMPLES - 1);
    localparam logic [3:0]  THRESH      = 4'(FULL_THRESH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        COMMIT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [6:0]       acc_q, acc_d;
    logic [7:0]       pat_q, pat_d;
    logic [2:0][7:0]  sensor_q, sensor_d;
    logic [2:0][3:0]  value_q, value_d;
    logic [2:0][7:0]  status_q, status_d;
    logic [2:0]       full_q, full_d;
    logic             update_q, update_d;

    logic [3:0]       pop_c;
    logic [6:0]       avg_c;
    logic [3:0]       value_c;
    logic [7:0]       status_c;
    logic             full_c;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Fill value never exceeds 8, so the 9-bit shift covers the all-ones bar too.
    always_comb begin
        pop_c    = popcount8(SENSOR_raw);
        avg_c    = acc_q >> SHIFT;
        value_c  = avg_c[3:0];
        status_c = 8'((9'd1 << value_c) - 9'd1);
        full_c   = (value_c >= THRESH);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        pat_d    = pat_q;
        sensor_d = sensor_q;
        value_d  = value_q;
        status_d = status_q;
        full_d   = full_q;
        update_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (scan_en) begin
                    state_d = SELECT;
                    sel_d   = idx_q;
                end
            end
            SELECT: begin
                acc_d   = '0;
                pat_d   = 8'hFF;
                cnt_d   = '0;
                state_d = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
            end
            SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                acc_d = acc_q + {3'b000, pop_c};
                pat_d = pat_q & SENSOR_raw;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SAMPLE_LAST) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                case (idx_q)
                    2'd0: begin
                        sensor_d[0] = pat_q;
                        value_d[0]  = value_c;
                        status_d[0] = status_c;
                        full_d[0]   = full_c;
                    end
                    2'd1: begin
                        sensor_d[1] = pat_q;
                        value_d[1]  = value_c;
                        status_d[1] = status_c;
                        full_d[1]   = full_c;
                    end
                    default: begin
                        sensor_d[2] = pat_q;
                        value_d[2]  = value_c;
                        status_d[2] = status_c;
                        full_d[2]   = full_c;
                    end
                endcase
                if (idx_q == 2'd2) begin
                    idx_d    = 2'd0;
                    update_d = 1'b1;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
                if (scan_en) begin
                    state_d = SELECT;
                    sel_d   = idx_d;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            pat_q    <= '0;
            sensor_q <= '0;
            value_q  <= '0;
            status_q <= '0;
            full_q   <= '0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            pat_q    <= pat_d;
            sensor_q <= sensor_d;
            value_q  <= value_d;
            status_q <= status_d;
            full_q   <= full_d;
            update_q <= update_d;
        end
    end

    assign SENSOR_sel  = sel_q;
    assign SENSOR_bin1 = sensor_q[0];
    assign SENSOR_bin2 = sensor_q[1];
    assign SENSOR_bin3 = sensor_q[2];
    assign VALUE_bin1  = value_q[0];
    assign VALUE_bin2  = value_q[1];
    assign VALUE_bin3  = value_q[2];
    assign STATUS_bin1 = status_q[0];
    assign STATUS_bin2 = status_q[1];
    assign STATUS_bin3 = status_q[2];
    assign FULL_flags  = full_q;
    assign update      = update_q;

endmodule

// File: tb/tb_bin_sensor_scanner.sv
// Directed bench for bin_sensor_scanner at default parameters (settle 4, 4 samples, threshold 7).
// Inputs change #1 after each rising edge; outputs are sampled at the same point.
module tb_bin_sensor_scanner;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       scan_en;
    logic [7:0] SENSOR_raw;
    logic [1:0] SENSOR_sel;
    logic [7:0] SENSOR_bin1, SENSOR_bin2, SENSOR_bin3;
    logic [3:0] VALUE_bin1, VALUE_bin2, VALUE_bin3;
    logic [7:0] STATUS_bin1, STATUS_bin2, STATUS_bin3;
    logic [2:0] FULL_flags;
    logic       update;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int upd_n = 0;
    int upd_cyc = 0;
    int base_cyc = 0;
    int prev_upd = 0;
    int upd_before = 0;

    bin_sensor_scanner dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .scan_en     (scan_en),
        .SENSOR_raw  (SENSOR_raw),
        .SENSOR_sel  (SENSOR_sel),
        .SENSOR_bin1 (SENSOR_bin1),
        .SENSOR_bin2 (SENSOR_bin2),
        .SENSOR_bin3 (SENSOR_bin3),
        .VALUE_bin1  (VALUE_bin1),
        .VALUE_bin2  (VALUE_bin2),
        .VALUE_bin3  (VALUE_bin3),
        .STATUS_bin1 (STATUS_bin1),
        .STATUS_bin2 (STATUS_bin2),
        .STATUS_bin3 (STATUS_bin3),
        .FULL_flags  (FULL_flags),
        .update      (update)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
        if (update) begin
            upd_n++;
            upd_cyc = cyc;
        end
    endtask

    // Called just after the edge that entered SELECT; returns just after the edge leaving COMMIT.
    task automatic bin_pass(input logic [7:0] settle_raw,
                            input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3,
                            input int drop_at);
        logic [7:0] smp [4];
        smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
        SENSOR_raw = settle_raw;
        tick();
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            SENSOR_raw = smp[i];
            if (i == drop_at) scan_en = 1'b0;
            tick();
        end
        SENSOR_raw = 8'h00;
        tick();
    endtask

    task automatic check_bin(input string tag, input int b,
                             input logic [7:0] sen, input logic [3:0] val, input logic [7:0] st);
        logic [7:0] o_sen;
        logic [3:0] o_val;
        logic [7:0] o_st;
        case (b)
            1:       begin o_sen = SENSOR_bin1; o_val = VALUE_bin1; o_st = STATUS_bin1; end
            2:       begin o_sen = SENSOR_bin2; o_val = VALUE_bin2; o_st = STATUS_bin2; end
            default: begin o_sen = SENSOR_bin3; o_val = VALUE_bin3; o_st = STATUS_bin3; end
        endcase
        check({tag, "_sensor"}, o_sen, sen);
        check({tag, "_value"},  o_val, val);
        check({tag, "_status"}, o_st,  st);
    endtask

    task automatic check_all_zero(input string tag);
        check_bin({tag, "_b1"}, 1, 8'h00, 4'd0, 8'h00);
        check_bin({tag, "_b2"}, 2, 8'h00, 4'd0, 8'h00);
        check_bin({tag, "_b3"}, 3, 8'h00, 4'd0, 8'h00);
        check({tag, "_full"}, FULL_flags, 3'b000);
        check({tag, "_update"}, update, 1'b0);
        check({tag, "_sel"}, SENSOR_sel, 2'd0);
    endtask

    initial begin
        Rst = 1'b1;
        scan_en = 1'b0;
        SENSOR_raw = 8'h00;
        repeat (2) tick();
        Rst = 1'b0;
        check_all_zero("reset");
        tick();
        check("idle_sel", SENSOR_sel, 2'd0);

        // Scan 1: every bin sees 0x0F
        scan_en = 1'b1;
        tick();
        base_cyc = cyc;
        check("scan1_sel0", SENSOR_sel, 2'd0);
        bin_pass(8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, -1);
        check("scan1_sel1", SENSOR_sel, 2'd1);
        check("scan1_noupd_b1", update, 1'b0);
        bin_pass(8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, -1);
        check("scan1_sel2", SENSOR_sel, 2'd2);
        bin_pass(8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, -1);
        check("scan1_update", update, 1'b1);
        check("scan1_upd_count", upd_n, 1);
        check("scan1_upd_latency", upd_cyc - base_cyc, 30);
        check_bin("scan1_b1", 1, 8'h0F, 4'd4, 8'h0F);
        check_bin("scan1_b2", 2, 8'h0F, 4'd4, 8'h0F);
        check_bin("scan1_b3", 3, 8'h0F, 4'd4, 8'h0F);
        check("scan1_full", FULL_flags, 3'b000);
        prev_upd = upd_cyc;

        // Scan 2: truncation/glitch, averaging/full, settle masking
        bin_pass(8'h00, 8'h01, 8'h03, 8'h05, 8'h00, -1);
        check_bin("trunc_b1", 1, 8'h00, 4'd1, 8'h01);
        check("trunc_b2_hold", VALUE_bin2, 4'd4);
        check("trunc_noupd", update, 1'b0);
        bin_pass(8'h00, 8'hFF, 8'hFF, 8'h7F, 8'h7F, -1);
        check_bin("avg_b2", 2, 8'h7F, 4'd7, 8'h7F);
        check("avg_full", FULL_flags, 3'b010);
        check("avg_b1_hold", VALUE_bin1, 4'd1);
        check("avg_b3_hold", STATUS_bin3, 8'h0F);
        bin_pass(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, -1);
        check_bin("settle_b3", 3, 8'h00, 4'd0, 8'h00);
        check("settle_full", FULL_flags, 3'b010);
        check("scan2_update", update, 1'b1);
        check("scan2_upd_count", upd_n, 2);
        check("scan2_upd_period", upd_cyc - prev_upd, 30);

        // Scan 3: scan_en drops in the third sample cycle of bin1
        bin_pass(8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 2);
        check_bin("drop_b1", 1, 8'h0F, 4'd4, 8'h0F);
        check("drop_sel", SENSOR_sel, 2'd0);
        repeat (3) tick();
        check("park_sel", SENSOR_sel, 2'd0);
        check("park_b2_hold", VALUE_bin2, 4'd7);
        scan_en = 1'b1;
        tick();
        check("resume_sel", SENSOR_sel, 2'd1);
        bin_pass(8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, -1);
        check_bin("max_b2", 2, 8'hFF, 4'd8, 8'hFF);
        check("max_full", FULL_flags, 3'b010);
        check("bin3_sel", SENSOR_sel, 2'd2);

        // Reset during bin3 SAMPLE: SELECT + 4 settle edges, then two samples
        SENSOR_raw = 8'hFF;
        repeat (5) tick();
        repeat (2) tick();
        upd_before = upd_n;
        Rst = 1'b1;
        tick();
        check_all_zero("midrst");
        Rst = 1'b0;
        scan_en = 1'b0;
        repeat (35) tick();
        check("midrst_no_update", upd_n, upd_before);
        check("midrst_b1_hold", VALUE_bin1, 4'd0);
        scan_en = 1'b1;
        tick();
        check("restart_sel", SENSOR_sel, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
